uart_tx_arbiter: RTL and testbench

Shares one UART transmit path among NUM_REQ byte-stream requesters. Grants are round-robin and held for a whole packet. Each packet is prefixed with a header byte carrying the requester ID. Bytes are issued to the UART write interface (write_data pulse plus bus_data_in) only while the transmitter FIFO reports not-full. The block sits between the on-chip packet sources and the uart_protocol write port.

---
 rtl/uart_tx_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART write port among NUM_REQ byte-stream
// requesters. Round-robin grants are held for a whole packet. Each packet is
// preceded by a header byte carrying the requester ID. A byte is written
// only when the TX FIFO reports not-full.
module uart_tx_arbiter #(
    parameter int         DATA_SIZE = 8,
    parameter int         NUM_REQ   = 4,
    parameter int         ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter logic [5:0] HDR_TAG   = 6'h28,
    parameter int         TIMEOUT   = 255
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]             req_last_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [7:0]                     tx_status_i,
    output logic                           tx_write_data_o,
    output logic [DATA_SIZE-1:0]           tx_bus_data_o,
    output logic                           busy_o,
    output logic [ID_W-1:0]                grant_id_o,
    output logic                           pkt_done_o,
    output logic                           abort_o
);

    // Header base: tag shifted above the ID field, cut to the byte width.
    localparam logic [DATA_SIZE-1:0] HDR_BASE = DATA_SIZE'(int'(HDR_TAG) << ID_W);
    // Counter is sized to hold TIMEOUT; with TIMEOUT=0 it never advances.
    localparam int TMO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TMO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_GAP,
        S_DATA,
        S_DONE
    } state_t;

    state_t                             state_q;
    logic [ID_W-1:0]                    grant_id_q;
    logic [ID_W-1:0]                    rr_ptr_q;
    logic [TMO_W-1:0]                   tmo_q;
    logic                               last_q;
    logic                               wr_q;
    logic [DATA_SIZE-1:0]               data_q;
    logic                               done_q;
    logic                               abort_q;

    logic                               full;
    logic [NUM_REQ-1:0][DATA_SIZE-1:0]  req_data_w;
    logic                               sel_valid;
    logic                               sel_last;
    logic [DATA_SIZE-1:0]               sel_data;
    logic [DATA_SIZE-1:0]               hdr_byte;
    logic [ID_W-1:0]                    rr_next;
    logic                               grant_vld_d;
    logic [ID_W-1:0]                    grant_id_d;
    logic                               tmo_hit;
    logic                               unused_status;

    // Only the FIFO-full flag of the status register matters here.
    assign full          = tx_status_i[0];
    assign unused_status = ^tx_status_i[7:1];

    // Flat byte bus viewed as one byte lane per requester.
    assign req_data_w = req_data_i;
    assign sel_valid  = req_valid_i[grant_id_q];
    assign sel_last   = req_last_i[grant_id_q];
    assign sel_data   = req_data_w[grant_id_q];
    assign hdr_byte   = HDR_BASE | DATA_SIZE'(grant_id_q);

    // The requester just served drops to lowest priority.
    assign rr_next = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

    // Abort fires on the idle DATA cycle that brings the count up to TIMEOUT.
    assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_W'(TMO_LIM));

    // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
    // The loop runs from the far end down, so the nearest valid entry wins.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_id_d  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            automatic int idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid_i[idx]) begin
                grant_vld_d = 1'b1;
                grant_id_d  = ID_W'(idx);
            end
        end
    end

    // Ready only for the granted requester, only in DATA, only if FIFO has room.
    always_comb begin
        req_ready_o = '0;
        if (state_q == S_DATA) begin
            req_ready_o[grant_id_q] = ~full;
        end
    end

    // Packet FSM. Strobe, byte, pkt_done and abort are all registered here.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            tmo_q      <= '0;
            last_q     <= 1'b0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_vld_d) begin
                        grant_id_q <= grant_id_d;
                        state_q    <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (!full) begin
                        wr_q    <= 1'b1;
                        data_q  <= hdr_byte;
                        last_q  <= 1'b0;
                        state_q <= S_GAP;
                    end
                end
                // Strobe is high during this cycle; the next write waits
                // at least one more cycle so the FIFO status can catch up.
                S_GAP: begin
                    if (last_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (sel_valid && !full) begin
                        wr_q    <= 1'b1;
                        data_q  <= sel_data;
                        last_q  <= sel_last;
                        tmo_q   <= '0;
                        state_q <= S_GAP;
                    end else if (!sel_valid && TIMEOUT != 0) begin
                        // Stalls on a full FIFO with valid high are not idle.
                        if (tmo_hit) begin
                            abort_q  <= 1'b1;
                            rr_ptr_q <= rr_next;
                            tmo_q    <= '0;
                            state_q  <= S_IDLE;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    rr_ptr_q <= rr_next;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_write_data_o = wr_q;
    assign tx_bus_data_o   = data_q;
    assign busy_o          = (state_q != S_IDLE);
    assign grant_id_o      = grant_id_q;
    assign pkt_done_o      = done_q;
    assign abort_o         = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (4 requesters, TIMEOUT=5).
module tb_uart_tx_arbiter;

    localparam int NP = 3;  // packets per requester in the random phase

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic [7:0]  tx_status = '0;
    logic        tx_write_data;
    logic [7:0]  tx_bus_data;
    logic        busy;
    logic [1:0]  grant_id;
    logic        pkt_done;
    logic        abort;

    uart_tx_arbiter #(
        .DATA_SIZE(8), .NUM_REQ(4), .HDR_TAG(6'h28), .TIMEOUT(5)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .tx_status_i(tx_status),
        .tx_write_data_o(tx_write_data), .tx_bus_data_o(tx_bus_data),
        .busy_o(busy), .grant_id_o(grant_id),
        .pkt_done_o(pkt_done), .abort_o(abort)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] sb_q[$];   // bytes seen on the strobe
    int         sc_q[$];   // cycle of each strobe
    int n_done = 0, n_abort = 0, done_cyc = 0, abort_cyc = 0;
    logic prev_strobe = 1'b0, prev_full = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Passive monitor: collects strobes and pulses, checks per-cycle rules.
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_write_data) begin
                chk("no_back_to_back", prev_strobe, 1'b0);
                chk("strobe_after_notfull", prev_full, 1'b0);
                sb_q.push_back(tx_bus_data);
                sc_q.push_back(cyc);
            end
            if (pkt_done) begin n_done++; done_cyc = cyc; end
            if (abort) begin n_abort++; abort_cyc = cyc; end
            chk("ready_onehot", ($countones(req_ready) <= 1), 1'b1);
            chk("ready_while_full", (|req_ready) & tx_status[0], 1'b0);
        end
        prev_strobe = tx_write_data;
        prev_full   = tx_status[0];
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic get_strobe(output logic [7:0] b, output int c);
        int k = 0;
        while (sb_q.size() == 0 && k < 300) begin tick(1); k++; end
        if (sb_q.size() == 0) begin
            chk("strobe_wait", 0, 1);
            b = '0; c = 0;
        end else begin
            b = sb_q.pop_front();
            c = sc_q.pop_front();
        end
    endtask

    // Offer one byte from requester g and return just after it is accepted.
    task automatic send_byte(input int g, input logic [7:0] d, input logic l);
        int k = 0;
        bit acc = 0;
        req_valid[g] = 1'b1;
        req_data[g*8 +: 8] = d;
        req_last[g] = l;
        while (!acc && k < 300) begin
            @(negedge clk);
            acc = req_ready[g];
            tick(1);
            k++;
        end
        req_valid[g] = 1'b0;
        req_last[g]  = 1'b0;
        if (!acc) chk("accept_wait", 0, 1);
    endtask

    task automatic wait_done(input int n0);
        int k = 0;
        while (n_done == n0 && k < 200) begin tick(1); k++; end
        chk("pkt_done_count", n_done, n0 + 1);
    endtask

    typedef struct packed {
        logic [3:0] mask;
        logic [7:0] dat;
        logic [1:0] g;
        logic [7:0] hdr;
    } vec_t;
    vec_t tbl[9];

    int plen[4][NP];
    logic [7:0] pb[4][NP][4];
    int pi[4], bi[4], gp[4], mp[4];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    initial begin
        logic [7:0] b;
        int c, c0, c1, n0, a0, fc, d0, k;
        logic [3:0] acc;

        // Single-byte packets; rr pointer starts at 2 after the first test.
        tbl[0] = '{4'b1111, 8'h5A, 2'd2, 8'hA2};
        tbl[1] = '{4'b1111, 8'h3C, 2'd3, 8'hA3};
        tbl[2] = '{4'b1111, 8'hC3, 2'd0, 8'hA0};
        tbl[3] = '{4'b1111, 8'h01, 2'd1, 8'hA1};
        tbl[4] = '{4'b0001, 8'hFF, 2'd0, 8'hA0};
        tbl[5] = '{4'b1001, 8'h80, 2'd3, 8'hA3};
        tbl[6] = '{4'b0110, 8'h7E, 2'd1, 8'hA1};
        tbl[7] = '{4'b0011, 8'h42, 2'd0, 8'hA0};
        tbl[8] = '{4'b1000, 8'h99, 2'd3, 8'hA3};

        // Reset state
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", tx_write_data, 0);
        chk("rst_bus", tx_bus_data, 0);
        chk("rst_done", pkt_done, 0);
        chk("rst_abort", abort, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_ready", req_ready, 0);
        reset = 1'b0;

        // Requester 1, two bytes, strobes two cycles apart
        n0 = n_done;
        send_byte(1, 8'h11, 0);
        send_byte(1, 8'h22, 1);
        get_strobe(b, c0); chk("t1_hdr", b, 8'hA1);
        get_strobe(b, c1); chk("t1_b0", b, 8'h11); chk("t1_gap0", c1 - c0, 2);
        get_strobe(b, c);  chk("t1_b1", b, 8'h22); chk("t1_gap1", c - c1, 2);
        wait_done(n0);
        chk("t1_done_cycle", done_cyc, c + 1);
        chk("t1_grant", grant_id, 1);

        // Table: arbitration order and header encoding
        for (int i = 0; i < 9; i++) begin
            n0 = n_done;
            for (int r = 0; r < 4; r++) begin
                req_data[r*8 +: 8] = ~tbl[i].dat;
                req_last[r] = 1'b1;
            end
            req_valid = tbl[i].mask;
            get_strobe(b, c);
            chk("tbl_hdr", b, tbl[i].hdr);
            chk("tbl_grant", grant_id, tbl[i].g);
            send_byte(tbl[i].g, tbl[i].dat, 1);
            get_strobe(b, c);
            chk("tbl_byte", b, tbl[i].dat);
            wait_done(n0);
            req_valid = '0;
            req_last  = '0;
        end

        // FIFO full for 10 cycles mid-packet
        n0 = n_done;
        send_byte(0, 8'h31, 0);
        get_strobe(b, c); chk("t3_hdr", b, 8'hA0);
        get_strobe(b, c); chk("t3_b0", b, 8'h31);
        tx_status[0] = 1'b1;
        req_valid[0] = 1'b1; req_data[7:0] = 8'h32; req_last[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_ready_full", req_ready[0], 0);
            chk("t3_no_strobe", tx_write_data, 0);
            tick(1);
        end
        tx_status[0] = 1'b0;
        fc = cyc;
        send_byte(0, 8'h32, 1);
        get_strobe(b, c); chk("t3_b1", b, 8'h32); chk("t3_resume", c, fc + 1);
        wait_done(n0);

        // Timeout abort, then requester 3 is served next
        n0 = n_done; a0 = n_abort;
        send_byte(2, 8'h41, 0);
        req_valid[3] = 1'b1; req_data[31:24] = 8'h55; req_last[3] = 1'b1;
        get_strobe(b, c); chk("t4_hdr", b, 8'hA2);
        get_strobe(b, c); chk("t4_b0", b, 8'h41);
        k = 0;
        while (n_abort == a0 && k < 50) begin tick(1); k++; end
        chk("t4_abort_count", n_abort, a0 + 1);
        chk("t4_abort_cycle", abort_cyc, c + 6);
        chk("t4_no_done", n_done, n0);
        get_strobe(b, c); chk("t4_next_hdr", b, 8'hA3);
        send_byte(3, 8'h55, 1);
        get_strobe(b, c); chk("t4_next_byte", b, 8'h55);
        wait_done(n0);

        // Reset mid-packet after two bytes
        n0 = n_done; a0 = n_abort;
        send_byte(1, 8'h61, 0);
        send_byte(1, 8'h62, 0);
        get_strobe(b, c); chk("t5_hdr", b, 8'hA1);
        get_strobe(b, c); chk("t5_b0", b, 8'h61);
        get_strobe(b, c); chk("t5_b1", b, 8'h62);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_strobe", tx_write_data, 0);
        chk("t5_bus", tx_bus_data, 0);
        chk("t5_grant", grant_id, 0);
        tick(3);
        chk("t5_no_strobe", sb_q.size(), 0);
        chk("t5_no_done", n_done, n0);
        chk("t5_no_abort", n_abort, a0);
        send_byte(0, 8'h81, 1);
        get_strobe(b, c); chk("t5_hdr_after", b, 8'hA0);
        get_strobe(b, c); chk("t5_byte_after", b, 8'h81);
        wait_done(n0);

        // Full rises right after an accept
        n0 = n_done;
        send_byte(2, 8'h71, 0);
        fc = cyc;
        tx_status[0] = 1'b1;
        req_valid[2] = 1'b1; req_data[23:16] = 8'h72; req_last[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_ready_full", req_ready[2], 0);
            tick(1);
        end
        tx_status[0] = 1'b0;
        c1 = cyc;
        send_byte(2, 8'h72, 1);
        get_strobe(b, c); chk("t6_hdr", b, 8'hA2);
        get_strobe(b, c); chk("t6_b0", b, 8'h71); chk("t6_b0_cycle", c, fc);
        get_strobe(b, c); chk("t6_b1", b, 8'h72); chk("t6_b1_cycle", c, c1 + 1);
        wait_done(n0);

        // Random phase: every requester queues NP packets, FIFO full at random
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        sb_q.delete(); sc_q.delete();
        for (int r = 0; r < 4; r++) begin
            pi[r] = 0; bi[r] = 0; gp[r] = 0; mp[r] = 0;
            for (int p = 0; p < NP; p++) begin
                plen[r][p] = $urandom_range(1, 4);
                for (int j = 0; j < 4; j++) pb[r][p][j] = 8'($urandom);
            end
        end
        // Expected stream: all queues stay valid, so grants rotate strictly
        // among requesters that still have packets left.
        begin
            int rr = 0;
            for (int n = 0; n < 4 * NP; n++) begin
                int g = 0;
                for (int j = 3; j >= 0; j--)
                    if (mp[(rr + j) % 4] < NP) g = (rr + j) % 4;
                exp_q.push_back(8'hA0 | 8'(g));  // (0x28 << 2) | id
                for (int j = 0; j < plen[g][mp[g]]; j++) exp_q.push_back(pb[g][mp[g]][j]);
                mp[g]++;
                rr = (g + 1) % 4;
            end
        end
        d0 = n_done; a0 = n_abort; k = 0;
        while ((n_done - d0) < 4 * NP && k < 5000) begin
            tx_status[0] = ($urandom_range(0, 9) < 3);
            for (int r = 0; r < 4; r++) begin
                if (pi[r] < NP) begin
                    // Mid-packet bubbles stay well short of the timeout.
                    if (bi[r] > 0 && gp[r] < 2 && $urandom_range(0, 3) == 0) begin
                        req_valid[r] = 1'b0;
                        gp[r]++;
                    end else begin
                        req_valid[r] = 1'b1;
                    end
                    req_data[r*8 +: 8] = pb[r][pi[r]][bi[r]];
                    req_last[r] = (bi[r] == plen[r][pi[r]] - 1);
                end else begin
                    req_valid[r] = 1'b0;
                    req_last[r]  = 1'b0;
                end
            end
            @(negedge clk);
            acc = req_valid & req_ready;
            tick(1);
            k++;
            for (int r = 0; r < 4; r++) begin
                if (acc[r]) begin
                    gp[r] = 0;
                    bi[r]++;
                    if (bi[r] == plen[r][pi[r]]) begin bi[r] = 0; pi[r]++; end
                end
            end
        end
        req_valid = '0; req_last = '0; tx_status = '0;
        tick(3);
        chk("rand_done_count", n_done - d0, 4 * NP);
        chk("rand_no_abort", n_abort, a0);
        while (sb_q.size() > 0) begin got_q.push_back(sb_q.pop_front()); void'(sc_q.pop_front()); end
        chk("rand_len", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk("rand_byte", got_q[i], exp_q[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
